hs_stream_checker: RTL and testbench
====================================

Name: hs_stream_checker

Overview:
- Sink end of the team's valid/ready stream protocol; consumes the output of a stream source or register slice under test.
- Generates `s_ready` with programmable pseudo-random backpressure.
- Checks received data against an incrementing sequence and monitors source-side protocol rules.
- Reports counts and a pass/fail verdict for directed and random regression benches.

Parameters:
- WIDTH, 32, stream data width.
- THROTTLE_W, 4, width of throttle control; LFSR bits compared against it.
- LFSR_SEED, 16'hACE1, reset/start seed of the backpressure LFSR; value 0 is replaced by 16'h0001.
- TIMEOUT_W, 12, watchdog width (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a check run.
- expect_cnt  in  16  number of beats in the run; sampled on start.
- throttle  in  THROTTLE_W  backpressure level; 0 = always ready.
- s_valid  in  1  source valid.
- s_data  in  WIDTH  source data.
- s_ready  out  1  sink ready, driven from a flop.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done=1: no data errors, no protocol error, no timeout.
- rx_cnt  out  16  beats accepted this run.
- err_data_cnt  out  16  mismatching beats; saturates at 16'hFFFF.
- err_proto  out  1  sticky source-protocol violation flag.
- timeout  out  1  watchdog fired (tied 0 without the macro).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; lfsr=LFSR_SEED; expected=0.
  - All outputs 0; s_ready=0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start, expect_cnt≠0 → RUN. Clear rx_cnt, err_data_cnt, err_proto, timeout, done, pass. Reload lfsr=seed, expected=0, latch expect_cnt and throttle.
  - IDLE/DONE + start, expect_cnt=0 → DONE directly, pass=1, counters cleared.
  - start in RUN is ignored.
- Ready generation:
  - LFSR is 16-bit Galois, taps 16'hB400, shifting once per cycle in RUN only.
  - Each RUN cycle: s_ready <= (lfsr[THROTTLE_W-1:0] >= throttle_latched).
  - throttle=0 gives s_ready=1 from the cycle after start.
  - s_ready=0 in IDLE/DONE.
- Handshake: beat = s_valid & s_ready at the clock edge.
  - On beat: rx_cnt+1.
  - If s_data≠expected, err_data_cnt+1 (saturating).
  - expected <= expected+1, wrapping mod 2^WIDTH.
- Completion: on the beat where rx_cnt+1 == expect_cnt_latched:
  - State → DONE and done=1; s_ready deasserts at the same edge.
  - No further beats are accepted.
  - pass = (err_data_cnt after this beat == 0) & ~err_proto & ~timeout.
- Protocol check (RUN only): previous cycle had s_valid=1 and s_ready=0.
  - If this cycle s_valid=0 → err_proto=1.
  - If s_data changed → err_proto=1.
  - err_proto is sticky until next start.
- Beats seen while s_ready=0 are not counted.
- Mid-run async reset: immediate return to reset values; no partial verdict retained.
- rx_cnt never exceeds expect_cnt; expect_cnt=16'hFFFF is legal.

Optional Feature:
- Macro: STREAM_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit watchdog counts RUN cycles without a beat and clears on every beat.
  - When it reaches all-ones: timeout=1, state → DONE, done=1, pass=0, s_ready=0.
- Undefined: no watchdog logic; timeout tied 0; RUN waits indefinitely.

Test Plan:
- throttle=0, expect_cnt=8, source sends 0..7 with continuous valid → s_ready high from cycle after start; done after 8th beat; rx_cnt=8, err_data_cnt=0, pass=1.
- throttle=8, expect_cnt=100, correct sequence → s_ready toggles per LFSR; rx_cnt=100, pass=1; s_ready=0 after done.
- expect_cnt=4, source sends 0,1,5,3 → err_data_cnt=1, pass=0, err_proto=0.
- Source drops s_valid while s_ready=0 mid-run → err_proto=1, pass=0 at done.
- start with expect_cnt=0 → DONE next cycle, pass=1, s_ready never asserted.
- With STREAM_TIMEOUT_EN, TIMEOUT_W=4, source idle after start → timeout=1, done=1, pass=0 after 15 idle RUN cycles.

Source files
------------

// File: rtl/hs_stream_checker.sv
// Valid/ready stream sink: LFSR-driven backpressure, incrementing-sequence data check,
// source protocol monitor and run verdict. Define STREAM_TIMEOUT_EN to add the idle watchdog.
module hs_stream_checker #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned THROTTLE_W = 4,
`ifdef STREAM_TIMEOUT_EN
    parameter int unsigned TIMEOUT_W  = 12,
`endif
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           expect_cnt,
    input  logic [THROTTLE_W-1:0] throttle,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           rx_cnt,
    output logic [15:0]           err_data_cnt,
    output logic                  err_proto,
    output logic                  timeout
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]      expected_q, expected_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]      exp_cnt_q, exp_cnt_d;
    logic [THROTTLE_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  err_proto_q, err_proto_d;
    logic                  pass_q, pass_d;
    logic                  s_ready_q, s_ready_d;
    logic                  pend_q, pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LFSR_W-1:0]     lfsr_nxt_c;
    logic                  beat_c;
    logic                  last_c;
`ifdef STREAM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  timeout_q, timeout_d;
`endif

    // Right-shifting Galois step of the backpressure LFSR
    assign lfsr_nxt_c = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    assign beat_c     = (state_q == RUN) && s_valid && s_ready_q;
    assign last_c     = beat_c && (CNT_W'(rx_cnt_q + 16'd1) == exp_cnt_q);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        expected_d  = expected_q;
        hold_d      = hold_q;
        exp_cnt_d   = exp_cnt_q;
        thr_d       = thr_q;
        rx_cnt_d    = rx_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_proto_d = err_proto_q;
        pass_d      = pass_q;
        s_ready_d   = 1'b0;
        pend_d      = 1'b0;
`ifdef STREAM_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_d      = SEED;
                    expected_d  = '0;
                    exp_cnt_d   = expect_cnt;
                    thr_d       = throttle;
                    rx_cnt_d    = '0;
                    err_cnt_d   = '0;
                    err_proto_d = 1'b0;
`ifdef STREAM_TIMEOUT_EN
                    wd_d        = '0;
                    timeout_d   = 1'b0;
`endif
                    if (expect_cnt == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d   = RUN;
                        pass_d    = 1'b0;
                        s_ready_d = (SEED[THROTTLE_W-1:0] >= throttle);
                    end
                end
            end

            RUN: begin
                lfsr_d    = lfsr_nxt_c;
                s_ready_d = (lfsr_nxt_c[THROTTLE_W-1:0] >= thr_q);
                // A stalled beat must be held: valid stays high and data stays put
                pend_d    = s_valid && !s_ready_q;
                hold_d    = s_data;
                if (pend_q && (!s_valid || (s_data != hold_q))) begin
                    err_proto_d = 1'b1;
                end
                if (beat_c) begin
                    rx_cnt_d   = CNT_W'(rx_cnt_q + 16'd1);
                    expected_d = WIDTH'(expected_q + WIDTH'(1));
                    if ((s_data != expected_q) && (err_cnt_q != '1)) begin
                        err_cnt_d = CNT_W'(err_cnt_q + 16'd1);
                    end
                end
`ifdef STREAM_TIMEOUT_EN
                if (beat_c) begin
                    wd_d = '0;
                end else begin
                    wd_d = TIMEOUT_W'(wd_q + TIMEOUT_W'(1));
                    if (wd_d == '1) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                        s_ready_d = 1'b0;
                        pass_d    = 1'b0;
                    end
                end
`endif
                if (last_c) begin
                    state_d   = DONE;
                    s_ready_d = 1'b0;
                    pass_d    = (err_cnt_d == '0) && !err_proto_d && !timeout;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            expected_q  <= '0;
            hold_q      <= '0;
            exp_cnt_q   <= '0;
            thr_q       <= '0;
            rx_cnt_q    <= '0;
            err_cnt_q   <= '0;
            err_proto_q <= 1'b0;
            pass_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef STREAM_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            expected_q  <= expected_d;
            hold_q      <= hold_d;
            exp_cnt_q   <= exp_cnt_d;
            thr_q       <= thr_d;
            rx_cnt_q    <= rx_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_proto_q <= err_proto_d;
            pass_q      <= pass_d;
            s_ready_q   <= s_ready_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef STREAM_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign s_ready      = s_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign rx_cnt       = rx_cnt_q;
    assign err_data_cnt = err_cnt_q;
    assign err_proto    = err_proto_q;
`ifdef STREAM_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_hs_stream_checker.sv
// Directed bench for hs_stream_checker: table of check runs plus hand sequences for
// zero-length runs, start-while-running and asynchronous reset mid-run.
module tb_hs_stream_checker;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [15:0]      expect_cnt;
    logic [TW-1:0]    throttle;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      rx_cnt;
    logic [15:0]      err_data_cnt;
    logic             err_proto;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hs_stream_checker #(
        .WIDTH      (WIDTH),
        .THROTTLE_W (TW),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expect_cnt   (expect_cnt),
        .throttle     (throttle),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .rx_cnt       (rx_cnt),
        .err_data_cnt (err_data_cnt),
        .err_proto    (err_proto),
        .timeout      (timeout)
    );

    // mode: 0 clean, 1 drop valid after a stall, 2 alter data during a stall, 3 every beat off by one
    typedef struct {
        logic [15:0] n;
        logic [3:0]  thr;
        int          bad_idx;
        logic [31:0] bad_val;
        int          mode;
        logic [15:0] e_err;
        logic        e_pass;
        logic        e_proto;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] ml;
        logic [31:0] d;
        logic        rdy;
        logic        prev_stall;
        logic        injected;
        int          sent;
        int          cyc;
        int          rdy_bad;
        @(negedge clk);
        start = 1'b1; expect_cnt = v.n; throttle = v.thr; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ml = 16'hACE1; sent = 0; cyc = 0; rdy_bad = 0; prev_stall = 1'b0; injected = 1'b0;
        while (done !== 1'b1 && cyc < 4000) begin
            rdy = s_ready;
            if (rdy !== (ml[3:0] >= v.thr)) rdy_bad++;
            if (v.mode == 3) d = 32'(sent + 1);
            else if (sent == v.bad_idx) d = v.bad_val;
            else d = 32'(sent);
            s_valid = 1'b1;
            s_data  = d;
            if (!injected && prev_stall && !rdy) begin
                if (v.mode == 1) begin
                    s_valid = 1'b0; injected = 1'b1;
                end else if (v.mode == 2) begin
                    s_data = d ^ 32'h100; injected = 1'b1;
                end
            end
            @(posedge clk);
            if (s_valid && rdy) sent++;
            prev_stall = s_valid && !rdy;
            ml = lfsr_step(ml);
            cyc++;
            @(negedge clk);
        end
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_ready_seq_errs", idx), 32'(rdy_bad), 32'd0);
        check($sformatf("v%0d_beats_sent", idx), 32'(sent), 32'(v.n));
        check($sformatf("v%0d_rx_cnt", idx), 32'(rx_cnt), 32'(v.n));
        check($sformatf("v%0d_err_data_cnt", idx), 32'(err_data_cnt), 32'(v.e_err));
        check($sformatf("v%0d_pass", idx), 32'(pass), 32'(v.e_pass));
        check($sformatf("v%0d_err_proto", idx), 32'(err_proto), 32'(v.e_proto));
        check($sformatf("v%0d_ready_after_done", idx), 32'(s_ready), 32'd0);
        check($sformatf("v%0d_busy_after_done", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_timeout", idx), 32'(timeout), 32'd0);
        if (v.thr == 4'd0) check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.n));
        // Source keeps offering data after completion; nothing more may be taken
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_rx_held", idx), 32'(rx_cnt), 32'(v.n));
        check($sformatf("v%0d_done_held", idx), 32'(done), 32'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'd8,   4'd0,  -1, 32'd0,   0, 16'd0,  1'b1, 1'b0};
        vecs[1] = '{16'd100, 4'd8,  -1, 32'd0,   0, 16'd0,  1'b1, 1'b0};
        vecs[2] = '{16'd4,   4'd0,   2, 32'd5,   0, 16'd1,  1'b0, 1'b0};
        vecs[3] = '{16'd20,  4'd8,  -1, 32'd0,   1, 16'd0,  1'b0, 1'b1};
        vecs[4] = '{16'd10,  4'd15,  9, 32'd100, 0, 16'd1,  1'b0, 1'b0};
        vecs[5] = '{16'd12,  4'd8,  -1, 32'd0,   2, 16'd0,  1'b0, 1'b1};
        vecs[6] = '{16'd5,   4'd4,  -1, 32'd0,   3, 16'd5,  1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; expect_cnt = '0; throttle = '0;
        s_valid = 1'b0; s_data = '0;
        #12;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_rx_cnt", 32'(rx_cnt), 32'd0);
        check("rst_err_data_cnt", 32'(err_data_cnt), 32'd0);
        check("rst_err_proto", 32'(err_proto), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-length run goes straight to DONE with a pass
        @(negedge clk);
        start = 1'b1; expect_cnt = 16'd0; throttle = 4'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_pass", 32'(pass), 32'd1);
        check("zero_s_ready", 32'(s_ready), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_rx_cnt", 32'(rx_cnt), 32'd0);

        // A start pulse during RUN must not restart the run
        @(negedge clk);
        start = 1'b1; expect_cnt = 16'd10; throttle = 4'd0;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data     = 32'(i);
            start      = (i == 3);
            expect_cnt = (i == 3) ? 16'd2 : 16'd10;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0; s_valid = 1'b0;
        check("restart_done", 32'(done), 32'd1);
        check("restart_rx_cnt", 32'(rx_cnt), 32'd10);
        check("restart_pass", 32'(pass), 32'd1);
        check("restart_err_data_cnt", 32'(err_data_cnt), 32'd0);

        // Asynchronous reset in the middle of a run drops everything at once
        @(negedge clk);
        start = 1'b1; expect_cnt = 16'd10; throttle = 4'd0;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 32'(i);
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_rx_before", 32'(rx_cnt), 32'd3);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rx_cnt", 32'(rx_cnt), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; s_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
